// File: rtl/write_sequencer.sv
// -----------------------------------------------------------------------------
// write_sequencer
//
// Iteration controller for the WRITE block. A job descriptor is captured on an
// accepted start; the sequencer then issues one configure pulse per iteration,
// counts WRITE's valid strobes to find the end of each iteration, advances the
// base address by the stride and either reconfigures or finishes.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   start                    job start pulse, accepted only in IDLE
//   num_iters ... max_clip   job descriptor, sampled when start is accepted
//   write_valid              WRITE's valid_out, one strobe per completed write
//   cfg_configure            one-cycle configure pulse to WRITE
//   cfg_num_reads_per_iter,
//   cfg_base_address,
//   cfg_min_clip,
//   cfg_max_clip             latched configuration presented to WRITE
//   iter_index               index of the current iteration (from 0)
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse at the end of the job
//   error                    sticky: a write_valid arrived outside RUN
//
// Handshake: start is a level sampled on the clock edge while IDLE; outside
// IDLE it is dropped, not queued. write_valid is counted only in RUN, one
// count per cycle it is high. All outputs are decoded from registers.
// -----------------------------------------------------------------------------
module write_sequencer #(
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int LOG_MAX_ADDRESS        = 16,
    parameter int OUTPUT_DATA_WIDTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_writes_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]        base_address,
    input  logic [LOG_MAX_ADDRESS-1:0]        address_stride,
    input  logic [OUTPUT_DATA_WIDTH-1:0]      min_clip,
    input  logic [OUTPUT_DATA_WIDTH-1:0]      max_clip,
    input  logic                              write_valid,
    output logic                              cfg_configure,
    output logic [LOG_MAX_READS_PER_ITER-1:0] cfg_num_reads_per_iter,
    output logic [LOG_MAX_ADDRESS-1:0]        cfg_base_address,
    output logic [OUTPUT_DATA_WIDTH-1:0]      cfg_min_clip,
    output logic [OUTPUT_DATA_WIDTH-1:0]      cfg_max_clip,
    output logic [LOG_MAX_ITERS-1:0]          iter_index,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_RUN    = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [LOG_MAX_ITERS-1:0] ITERS_ONE =
        {{(LOG_MAX_ITERS-1){1'b0}}, 1'b1};
    localparam logic [LOG_MAX_READS_PER_ITER-1:0] WRITES_ONE =
        {{(LOG_MAX_READS_PER_ITER-1){1'b0}}, 1'b1};

    // Current state; kept as a named register so checkers can bind to it.
    state_t state, state_next;

    logic [LOG_MAX_READS_PER_ITER-1:0] num_writes_q, num_writes_next;
    logic [LOG_MAX_ADDRESS-1:0]        stride_q,     stride_next;
    logic [OUTPUT_DATA_WIDTH-1:0]      min_clip_q,   min_clip_next;
    logic [OUTPUT_DATA_WIDTH-1:0]      max_clip_q,   max_clip_next;
    logic [LOG_MAX_ITERS-1:0]          iters_left,   iters_left_next;
    logic [LOG_MAX_READS_PER_ITER-1:0] writes_left,  writes_left_next;
    logic [LOG_MAX_ADDRESS-1:0]        cur_address,  cur_address_next;
    logic [LOG_MAX_ITERS-1:0]          iter_idx_q,   iter_idx_next;
    logic                              error_q,      error_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            num_writes_q <= '0;
            stride_q     <= '0;
            min_clip_q   <= '0;
            max_clip_q   <= '0;
            iters_left   <= '0;
            writes_left  <= '0;
            cur_address  <= '0;
            iter_idx_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            state        <= state_next;
            num_writes_q <= num_writes_next;
            stride_q     <= stride_next;
            min_clip_q   <= min_clip_next;
            max_clip_q   <= max_clip_next;
            iters_left   <= iters_left_next;
            writes_left  <= writes_left_next;
            cur_address  <= cur_address_next;
            iter_idx_q   <= iter_idx_next;
            error_q      <= error_next;
        end
    end

    always_comb begin
        state_next       = state;
        num_writes_next  = num_writes_q;
        stride_next      = stride_q;
        min_clip_next    = min_clip_q;
        max_clip_next    = max_clip_q;
        iters_left_next  = iters_left;
        writes_left_next = writes_left;
        cur_address_next = cur_address;
        iter_idx_next    = iter_idx_q;
        error_next       = error_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    error_next = 1'b0;
                    if (num_iters != '0 && num_writes_per_iter != '0) begin
                        num_writes_next  = num_writes_per_iter;
                        stride_next      = address_stride;
                        min_clip_next    = min_clip;
                        max_clip_next    = max_clip;
                        iters_left_next  = num_iters;
                        cur_address_next = base_address;
                        iter_idx_next    = '0;
                        state_next       = S_CONFIG;
                    end else begin
                        // Empty job: nothing to configure, report completion.
                        state_next = S_DONE;
                    end
                end
            end
            S_CONFIG: begin
                writes_left_next = num_writes_q;
                state_next       = S_RUN;
            end
            S_RUN: begin
                if (write_valid) begin
                    writes_left_next = writes_left - WRITES_ONE;
                    if (writes_left == WRITES_ONE) begin
                        state_next = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (iters_left == ITERS_ONE) begin
                    state_next = S_DONE;
                end else begin
                    iters_left_next  = iters_left - ITERS_ONE;
                    // Address wraps modulo 2^LOG_MAX_ADDRESS by truncation.
                    cur_address_next = cur_address + stride_q;
                    iter_idx_next    = iter_idx_q + ITERS_ONE;
                    state_next       = S_CONFIG;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A stray strobe wins over the clear of an accepted start in the same
        // cycle, so the fault is never lost.
        if (write_valid && state != S_RUN) begin
            error_next = 1'b1;
        end
    end

    assign cfg_configure          = (state == S_CONFIG);
    assign busy                   = (state != S_IDLE);
    assign done                   = (state == S_DONE);
    assign error                  = error_q;
    assign cfg_num_reads_per_iter = num_writes_q;
    assign cfg_base_address       = cur_address;
    assign cfg_min_clip           = min_clip_q;
    assign cfg_max_clip           = max_clip_q;
    assign iter_index             = iter_idx_q;

endmodule

// File: doc/write_sequencer.md
# write_sequencer

Iteration controller for the WRITE block. It takes a job descriptor (iteration count, writes per iteration, base address, address stride, clip bounds) and issues one configure pulse per iteration to WRITE, advancing the base address by the stride each time. It counts WRITE's `valid_out` strobes to detect the end of each iteration, then reconfigures or finishes. It sits between the top-level control and WRITE's CONFIGURE interface.

## Interface
Parameters:
- `LOG_MAX_ITERS`, 16, width of the iteration count
- `LOG_MAX_READS_PER_ITER`, 16, width of the writes-per-iteration count
- `LOG_MAX_ADDRESS`, 16, address width
- `OUTPUT_DATA_WIDTH`, 4, clip value width

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  job start pulse; accepted only in IDLE.
- `num_iters`  in  LOG_MAX_ITERS  iterations in the job; sampled when `start` is accepted.
- `num_writes_per_iter`  in  LOG_MAX_READS_PER_ITER  writes per iteration; sampled on start.
- `base_address`  in  LOG_MAX_ADDRESS  address for iteration 0; sampled on start.
- `address_stride`  in  LOG_MAX_ADDRESS  address increment between iterations; sampled on start.
- `min_clip`, `max_clip`  in  OUTPUT_DATA_WIDTH  clip bounds; sampled on start.
- `write_valid`  in  1  WRITE's `valid_out`; one strobe per completed write.
- `cfg_configure`  out  1  configure pulse to WRITE.
- `cfg_num_reads_per_iter`  out  LOG_MAX_READS_PER_ITER  to WRITE.
- `cfg_base_address`  out  LOG_MAX_ADDRESS  to WRITE.
- `cfg_min_clip`, `cfg_max_clip`  out  OUTPUT_DATA_WIDTH  to WRITE.
- `iter_index`  out  LOG_MAX_ITERS  index of the current iteration, starting at 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of the job.
- `error`  out  1  sticky; set by a `write_valid` outside RUN; cleared on an accepted start.

## Operation
- Registers: latched job fields, `iters_left`, `writes_left`, `cur_address`, `iter_index`, error flag, state.
- Outputs are decoded from registers only; there are no combinational paths from inputs to outputs.
- State IDLE:
  - On `start` with `num_iters`≠0 and `num_writes_per_iter`≠0: latch all fields, set `cur_address`=`base_address`, `iter_index`=0, clear `error`, go to CONFIG.
  - On `start` with either count zero: latch nothing except clearing `error`, go directly to DONE.
- State CONFIG: `cfg_configure`=1 for exactly one cycle; load `writes_left`=`num_writes_per_iter`; go to RUN.
- State RUN: each cycle with `write_valid`=1 decrements `writes_left`. When `write_valid`=1 and `writes_left`==1, go to NEXT.
- State NEXT:
  - If `iters_left`==1: go to DONE.
  - Otherwise: decrement `iters_left`, `cur_address` += `address_stride` (modulo 2^LOG_MAX_ADDRESS, wraps silently), increment `iter_index`, go to CONFIG.
- State DONE: `done`=1 for one cycle; go to IDLE.
- `cfg_*` data outputs always present the latched values, with `cfg_base_address`=`cur_address`. They are stable throughout CONFIG and RUN.
- `start` outside IDLE is ignored; it is not queued.
- `write_valid` in IDLE, CONFIG, NEXT or DONE is not counted and sets `error`.

## Timing
- Reset (async assert): state IDLE. All outputs are 0: `cfg_configure`, `busy`, `done`, `error`, `iter_index`, and all `cfg_*` buses. All counters are 0.
- Reset released mid-job: the job is abandoned; no `done` pulse is produced.
- Start latency: `start` sampled at edge T → `cfg_configure` high in cycle T+1 → RUN from T+2.
- The earliest `write_valid` counted is in cycle T+2.
- Iteration turnaround: last `write_valid` in cycle W → NEXT in W+1 → `cfg_configure` in W+2.
- Job end: last write of the last iteration in cycle W → `done` in W+2 → IDLE in W+3. The next start is accepted at the W+3 edge at the earliest.
- Zero-count start at edge T: `done` in T+1; `busy` is high only in T+1; `cfg_configure` is never asserted.
- `write_valid` may be high on consecutive cycles; every strobe in RUN is counted.

## Test plan
- Basic job: start with iters=1, writes=3, base=0x0100, 3 `write_valid` strobes → exactly one `cfg_configure` with address 0x0100 and reads=3; `done` two cycles after the third strobe.
- Multi-iteration: iters=3, writes=2, base=0x0010, stride=0x0020, back-to-back strobes → configure pulses carry addresses 0x0010, 0x0030, 0x0050 with `iter_index` 0,1,2; `done` once.
- Wrap and clip pass-through: base=0xFFF0, stride=0x0020, iters=2, min=1, max=6 → second address is 0x0010; `cfg_min_clip`=1 and `cfg_max_clip`=6 during both iterations.
- Zero and ignored starts: start with iters=0 → `done` next cycle and no configure. A start pulse during RUN → no effect, and the job finishes normally.
- Error and reset: `write_valid` in IDLE → `error`=1, which stays set until the next accepted start clears it. Assert `rst` in the middle of RUN → all outputs 0 immediately, with no `done` pulse.
